// File: rtl/inst_fetch.sv
// inst_fetch: fetches 512-bit lines into a 2-slot buffer and streams them as 32-bit
// instructions until the HALT word is handed off.
module inst_fetch #(
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_data_valid,
   input  logic [511:0]      mem_data,
   output logic              inst_valid,
   output logic [31:0]       inst,
   input  logic              inst_ready,
   output logic              busy,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_n;
   logic [511:0] line_q [2];
   logic [511:0] line_n;
   logic [1:0] vld, vld_n;
   logic head, tail, head_n, tail_n;
   logic [3:0] wptr, wptr_n;
   logic [ADDR_W-1:0] next_addr;
   logic outstanding, drop;
   logic run, fire, last, halt_acc, flush, wr, ld, inst_valid_n;
   logic [31:0] inst_n;

   assign run         = state == RUN;
   assign busy        = run;
   assign done        = state == DONE;
   assign fire        = inst_valid && inst_ready;
   assign last        = fire && &wptr;
   assign halt_acc    = fire && inst == HALT_WORD;
   assign flush       = start || halt_acc;
   assign wr          = mem_data_valid && outstanding && !drop && run;
   assign mem_rd_req  = run && !outstanding && !drop && !(&vld);
   assign mem_rd_addr = next_addr;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;

   always_comb begin
      state_n = start ? RUN : (run && halt_acc) ? DONE : state;
   end

   // head is the slot being serialized, tail the slot the next response lands in
   always_comb begin
      vld_n = vld;
      if (last) vld_n[head] = 1'b0;
      if (wr) vld_n[tail] = 1'b1;
      if (flush) vld_n = '0;
      head_n       = flush ? 1'b0 : head ^ last;
      tail_n       = flush ? 1'b0 : tail ^ wr;
      wptr_n       = flush ? 4'd0 : wptr + 4'(fire);
      ld           = run && !flush && (!inst_valid || fire);
      line_n       = (wr && tail == head_n) ? mem_data : line_q[head_n];
      inst_valid_n = ld ? vld_n[head_n] : (run && !flush && inst_valid);
      inst_n       = ld ? line_n[{wptr_n, 5'd0} +: 32] : inst;
   end

   always_ff @(posedge clk)
      if (wr) line_q[tail] <= mem_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld         <= '0;
         head        <= 1'b0;
         tail        <= 1'b0;
         wptr        <= '0;
         next_addr   <= '0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         inst_valid  <= 1'b0;
         inst        <= '0;
      end else begin
         vld         <= vld_n;
         head        <= head_n;
         tail        <= tail_n;
         wptr        <= wptr_n;
         inst_valid  <= inst_valid_n;
         inst        <= inst_n;
         next_addr   <= start ? '0 : next_addr + ADDR_W'(mem_rd_req);
         outstanding <= !start && (mem_rd_req || (outstanding && !mem_data_valid));
         // a request in flight at restart leaves one orphan response to swallow
         drop        <= start ? (mem_rd_req || ((outstanding || drop) && !mem_data_valid))
                              : drop && !mem_data_valid;
      end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random memory latency and consumer backpressure against a program-order
// reference stream; a negedge monitor scores every accepted instruction.
module tb_inst_fetch;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   logic clk = 0, rst_n = 0, start = 0, mem_rd_req, mem_data_valid = 0;
   logic inst_valid, inst_ready = 0, busy, done;
   logic [15:0] mem_rd_addr;
   logic [511:0] mem_data = '0;
   logic [31:0] inst;

   always #5 clk = ~clk;

   inst_fetch dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_req(mem_rd_req),
      .mem_rd_addr(mem_rd_addr), .mem_data_valid(mem_data_valid), .mem_data(mem_data),
      .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready), .busy(busy), .done(done));

   logic rst2_n = 0, start2 = 0, req2, dv2 = 0, iv2, rdy2 = 1, busy2, done2, w2_fin = 0;
   logic [1:0] addr2;
   logic [511:0] data2 = '0;
   logic [31:0] inst2;

   inst_fetch #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst_n(rst2_n), .start(start2), .mem_rd_req(req2),
      .mem_rd_addr(addr2), .mem_data_valid(dv2), .mem_data(data2),
      .inst_valid(iv2), .inst(inst2), .inst_ready(rdy2), .busy(busy2), .done(done2));

   typedef struct {logic [511:0] d; int due; int ep;} resp_t;
   resp_t pend[$];
   logic [31:0] exp_q[$];
   int errors = 0, checks = 0;
   int cyc = 0, epoch = 0, exp_addr = 0, req_since = 0, acc_words = 0;
   int seed_v = 0, halt_l = 0, halt_k = 0, lat_lo = 1, lat_hi = 1, rdy_pct = 100;
   bit restart_req = 0, first_live = 0, lat_pend = 0, halt_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input int l, input int k);
      return (l == halt_l && k == halt_k) ? HALT : {1'b0, seed_v[14:0], l[11:0], k[3:0]};
   endfunction

   function automatic logic [511:0] line_of(input int l);
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = word_of(l, k);
      return r;
   endfunction

   task automatic build_stream();
      bit stop = 0;
      exp_q.delete();
      for (int l = 0; l <= halt_l && !stop; l++)
         for (int k = 0; k < 16 && !stop; k++) begin
            exp_q.push_back(word_of(l, k));
            stop = (l == halt_l && k == halt_k);
         end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (lat_pend) begin
         chk("lat1_inst_valid", inst_valid, 1);
         lat_pend = 0;
      end
      if (restart_req) begin
         restart_req = 0;
         start = 0;
         epoch++;
         build_stream();
         exp_addr = 0;
         req_since = 0;
         acc_words = 0;
         first_live = 1;
         halt_seen = 0;
      end
      if (mem_rd_req) begin
         chk("req_only_busy", busy, 1);
         chk("one_outstanding", pend.size(), 0);
         chk("req_addr", mem_rd_addr, exp_addr);
         chk("slot_free", (req_since - acc_words / 16) < 2, 1);
         pend.push_back(resp_t'{line_of(int'(mem_rd_addr)), cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
         exp_addr = (exp_addr + 1) & 16'hFFFF;
         req_since++;
      end
      mem_data_valid = 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         mem_data_valid = 1;
         mem_data = pend[0].d;
         if (pend[0].ep == epoch && first_live) begin
            first_live = 0;
            lat_pend = 1;
         end
         void'(pend.pop_front());
      end
      inst_ready = $urandom_range(99, 0) < rdy_pct;
   endtask

   task automatic do_start(input int s, input int hl, input int hk);
      bit exp_first;
      seed_v = s;
      halt_l = hl;
      halt_k = hk;
      exp_first = pend.size() == 0;
      start = 1;
      restart_req = 1;
      step();
      if (exp_first) begin
         chk("first_req", mem_rd_req, 1);
         chk("first_addr", mem_rd_addr, 0);
      end
   endtask

   task automatic run_done(input int budget);
      int n = 0;
      while (!(done && halt_seen && exp_q.size() == 0) && n < budget) begin
         step();
         n++;
      end
      chk("done_reached", done && exp_q.size() == 0, 1);
      chk("busy_after_done", busy, 0);
      chk("inst_valid_after_done", inst_valid, 0);
      repeat (20) step();
      chk("drained", pend.size(), 0);
   endtask

   logic prev_hold = 0;
   logic [31:0] prev_inst = '0;
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n) begin
         if (prev_hold) begin
            chk("hold_valid", inst_valid, 1);
            chk("hold_inst", inst, prev_inst);
         end
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_inst: got %0h expected none", inst);
            end else begin
               e = exp_q.pop_front();
               chk("inst", inst, e);
            end
            acc_words++;
            if (inst == HALT) halt_seen = 1;
         end
         prev_hold = inst_valid && !inst_ready && !start;
         prev_inst = inst;
      end else prev_hold = 0;
   end

   initial begin
      int got[$];
      int due = -1, c = 0;
      repeat (2) @(posedge clk);
      #1;
      rst2_n = 1;
      start2 = 1;
      @(posedge clk);
      #1;
      start2 = 0;
      while (got.size() < 5 && c < 400) begin
         c++;
         dv2 = (c == due);
         if (req2) begin
            got.push_back(int'(addr2));
            due = c + 2;
         end
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 5; i++) chk("wrap_addr", (i < got.size()) ? got[i] : 99, i % 4);
      w2_fin = 1;
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", mem_rd_req, 0);
      chk("rst_addr", mem_rd_addr, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1;
      repeat (3) step();
      chk("idle_busy", busy, 0);
      chk("idle_req", mem_rd_req, 0);

      lat_lo = 1; lat_hi = 1; rdy_pct = 100;
      do_start(1, 3, 5);
      run_done(600);

      lat_lo = 12; lat_hi = 12;
      do_start(2, 1, 7);
      run_done(600);

      lat_lo = 1; lat_hi = 6; rdy_pct = 30;
      do_start(3, 4, 15);
      run_done(3000);

      lat_lo = 3; lat_hi = 8; rdy_pct = 70;
      do_start(4, 6, 2);
      n = 0;
      while (!(pend.size() > 0 && acc_words > 20) && n < 500) begin
         step();
         n++;
      end
      chk("restart_window", pend.size() > 0, 1);
      do_start(5, 2, 9);
      run_done(2000);

      do_start(6, 0, 0);
      run_done(400);

      lat_lo = 1; lat_hi = 2; rdy_pct = 100;
      do_start(7, 5, 3);
      n = 0;
      while (acc_words < 20 && n < 500) begin
         step();
         n++;
      end
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_req", mem_rd_req, 0);
      chk("mid_rst_addr", mem_rd_addr, 0);
      chk("mid_rst_inst_valid", inst_valid, 0);
      chk("mid_rst_inst", inst, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      pend.delete();
      exp_q.delete();
      repeat (3) step();
      rst_n = 1;
      repeat (5) begin
         step();
         chk("post_rst_idle", {busy, inst_valid, mem_rd_req, done}, 0);
      end
      do_start(8, 2, 4);
      run_done(800);

      n = 0;
      while (!w2_fin && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("wrap_finished", w2_fin, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
